or_gate_checker: RTL and testbench

OR_GATE_CHECKER -- requirements
Module: or_gate_checker

---
 rtl/or_gate_checker.sv | 180 ++++++++++++++++++
 tb/tb_or_gate_checker.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/or_gate_checker.sv
// or_gate_checker: sweeps the four input vectors into an external OR gate and counts mismatches.
// Define OR_CHK_FAIL_CAPTURE_EN to add first-failure capture outputs.
module or_gate_checker #(
    parameter int unsigned SETTLE_CYCLES = 2,
    parameter int unsigned PASSES        = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    output logic       x_out,
    output logic       y_out,
    input  logic       z_in,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [3:0] err_count,
`ifdef OR_CHK_FAIL_CAPTURE_EN
    output logic [1:0] first_fail_vec,
    output logic       first_fail_valid,
`endif
    output logic [1:0] vec_idx
);

    localparam int unsigned CNT_W = 4;
    localparam int unsigned ERR_W = 4;
    localparam int unsigned VEC_W = 2;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        SAMPLE = 2'd2,
        DONE   = 2'd3
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [CNT_W-1:0]   sweep_q, sweep_d;
    logic [VEC_W-1:0]   vec_q, vec_d;
    logic [ERR_W-1:0]   err_q, err_d;
    logic               x_q, x_d;
    logic               y_q, y_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               pass_q, pass_d;
    logic               mismatch_c;
    logic [ERR_W-1:0]   err_inc_c;
`ifdef OR_CHK_FAIL_CAPTURE_EN
    logic [VEC_W-1:0]   ff_vec_q, ff_vec_d;
    logic               ff_valid_q, ff_valid_d;
`endif

    // Next-state and registered-output logic
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        sweep_d    = sweep_q;
        vec_d      = vec_q;
        err_d      = err_q;
        x_d        = x_q;
        y_d        = y_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        pass_d     = pass_q;
        mismatch_c = z_in != (x_q | y_q);
        err_inc_c  = (mismatch_c && (err_q != '1)) ? err_q + ERR_W'(1) : err_q;
`ifdef OR_CHK_FAIL_CAPTURE_EN
        ff_vec_d   = ff_vec_q;
        ff_valid_d = ff_valid_q;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = SETTLE;
                    cnt_d   = '0;
                    sweep_d = '0;
                    vec_d   = '0;
                    x_d     = 1'b0;
                    y_d     = 1'b0;
                    busy_d  = 1'b1;
                    pass_d  = 1'b0;
                    err_d   = '0;
`ifdef OR_CHK_FAIL_CAPTURE_EN
                    ff_vec_d   = '0;
                    ff_valid_d = 1'b0;
`endif
                end
            end
            SETTLE: begin
                if (cnt_q == CNT_W'(SETTLE_CYCLES - 1)) begin
                    state_d = SAMPLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            SAMPLE: begin
                err_d = err_inc_c;
                cnt_d = '0;
`ifdef OR_CHK_FAIL_CAPTURE_EN
                if (mismatch_c && !ff_valid_q) begin
                    ff_vec_d   = vec_q;
                    ff_valid_d = 1'b1;
                end
`endif
                if (vec_q != VEC_W'(3)) begin
                    state_d    = SETTLE;
                    vec_d      = vec_q + VEC_W'(1);
                    {x_d, y_d} = vec_q + VEC_W'(1);
                end else if (sweep_q != CNT_W'(PASSES - 1)) begin
                    state_d = SETTLE;
                    vec_d   = '0;
                    x_d     = 1'b0;
                    y_d     = 1'b0;
                    sweep_d = sweep_q + CNT_W'(1);
                end else begin
                    state_d = DONE;
                    vec_d   = '0;
                    x_d     = 1'b0;
                    y_d     = 1'b0;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    pass_d  = (err_inc_c == '0);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            sweep_q <= '0;
            vec_q   <= '0;
            err_q   <= '0;
            x_q     <= 1'b0;
            y_q     <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
`ifdef OR_CHK_FAIL_CAPTURE_EN
            ff_vec_q   <= '0;
            ff_valid_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sweep_q <= sweep_d;
            vec_q   <= vec_d;
            err_q   <= err_d;
            x_q     <= x_d;
            y_q     <= y_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            pass_q  <= pass_d;
`ifdef OR_CHK_FAIL_CAPTURE_EN
            ff_vec_q   <= ff_vec_d;
            ff_valid_q <= ff_valid_d;
`endif
        end
    end

    assign x_out     = x_q;
    assign y_out     = y_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign pass      = pass_q;
    assign err_count = err_q;
    assign vec_idx   = vec_q;
`ifdef OR_CHK_FAIL_CAPTURE_EN
    assign first_fail_vec   = ff_vec_q;
    assign first_fail_valid = ff_valid_q;
`endif

endmodule

// File: tb/tb_or_gate_checker.sv
// Bench for or_gate_checker: a default instance and a PASSES=6 instance, checked each cycle
// against an arithmetic timeline model driven by an emulated OR / stuck-0 / AND / noisy gate.
module tb_or_gate_checker;

    logic clk = 1'b0;
    logic rst;
    logic start;
    logic z_in;
    logic sel;

    logic       x1, y1, b1, d1, p1;
    logic [3:0] e1;
    logic [1:0] v1;
    logic       x6, y6, b6, d6, p6;
    logic [3:0] e6;
    logic [1:0] v6;
`ifdef OR_CHK_FAIL_CAPTURE_EN
    logic [1:0] fv1, fv6;
    logic       ff1, ff6;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    or_gate_checker dut1 (
        .clk(clk), .rst(rst), .start(start & ~sel),
        .x_out(x1), .y_out(y1), .z_in(z_in),
        .busy(b1), .done(d1), .pass(p1), .err_count(e1),
`ifdef OR_CHK_FAIL_CAPTURE_EN
        .first_fail_vec(fv1), .first_fail_valid(ff1),
`endif
        .vec_idx(v1)
    );

    or_gate_checker #(.SETTLE_CYCLES(2), .PASSES(6)) dut6 (
        .clk(clk), .rst(rst), .start(start & sel),
        .x_out(x6), .y_out(y6), .z_in(z_in),
        .busy(b6), .done(d6), .pass(p6), .err_count(e6),
`ifdef OR_CHK_FAIL_CAPTURE_EN
        .first_fail_vec(fv6), .first_fail_valid(ff6),
`endif
        .vec_idx(v6)
    );

    wire       o_x    = sel ? x6 : x1;
    wire       o_y    = sel ? y6 : y1;
    wire       o_busy = sel ? b6 : b1;
    wire       o_done = sel ? d6 : d1;
    wire       o_pass = sel ? p6 : p1;
    wire [3:0] o_err  = sel ? e6 : e1;
    wire [1:0] o_vec  = sel ? v6 : v1;
`ifdef OR_CHK_FAIL_CAPTURE_EN
    wire [1:0] o_fv   = sel ? fv6 : fv1;
    wire       o_ff   = sel ? ff6 : ff1;
`endif

    task automatic check_eq(input string tag, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Emulated gate under test: 0=OR, 1=stuck at 0, 2=AND, 3=OR (noise added by caller)
    function automatic bit gate(input int mode, input int v);
        bit a, b;
        a = bit'((v >> 1) & 1);
        b = bit'(v & 1);
        case (mode)
            1:       return 1'b0;
            2:       return a & b;
            default: return a | b;
        endcase
    endfunction

    // One run: start driven now; model checks every cycle until the IDLE cycle after DONE
    task automatic run(input int mode, input bit hold, input int mid_start, input bit do_rst,
                       input int exp_err);
        int  s, p, len, t, v, err, ffvec, ph;
        bit  ffv, aborted, rst_chk, zz, flip;
        s = 2;
        p = sel ? 6 : 1;
        len = 4 * p * (s + 1);
        err = 0; ffv = 0; ffvec = 0; aborted = 0; rst_chk = 0;
        start = 1'b1;
        for (int j = 1; j <= len + 2; j++) begin
            @(negedge clk);
            if (!hold) start = (j == mid_start);
            if (rst_chk) begin
                rst = 1'b0;
                rst_chk = 0;
                check_eq("rst_busy", o_busy, 0);
                check_eq("rst_x", o_x, 0);
                check_eq("rst_y", o_y, 0);
                check_eq("rst_err", o_err, 0);
                check_eq("rst_vec", o_vec, 0);
                check_eq("rst_pass", o_pass, 0);
            end
            if (aborted) begin
                check_eq("abort_done", o_done, 0);
                check_eq("abort_busy", o_busy, 0);
                continue;
            end
            if (j <= len) begin
                t  = j - 1;
                ph = t % (s + 1);
                v  = (t / (s + 1)) % 4;
                check_eq("busy", o_busy, 1);
                check_eq("done", o_done, 0);
                check_eq("pass_run", o_pass, 0);
                check_eq("vec", o_vec, v);
                check_eq("x", o_x, (v >> 1) & 1);
                check_eq("y", o_y, v & 1);
                check_eq("err_run", o_err, err);
`ifdef OR_CHK_FAIL_CAPTURE_EN
                check_eq("ffv_run", o_ff, int'(ffv));
                if (ffv) check_eq("ffvec_run", o_fv, ffvec);
`endif
                flip = (mode == 3) && ($urandom_range(0, 3) == 0);
                zz   = gate(mode, v) ^ flip;
                z_in = zz;
                if (ph == s && zz != gate(0, v)) begin
                    if (!ffv) begin ffv = 1; ffvec = v; end
                    if (err < 15) err++;
                end
                if (do_rst && v == 2 && ph == 0) begin
                    rst = 1'b1;
                    aborted = 1;
                    rst_chk = 1;
                end
            end else begin
                check_eq(j == len + 1 ? "done_pulse" : "done_after", o_done, int'(j == len + 1));
                check_eq("busy_end", o_busy, 0);
                check_eq("pass_end", o_pass, int'(err == 0));
                check_eq("err_end", o_err, err);
                check_eq("x_end", o_x, 0);
                check_eq("y_end", o_y, 0);
                check_eq("vec_end", o_vec, 0);
`ifdef OR_CHK_FAIL_CAPTURE_EN
                check_eq("ffv_end", o_ff, int'(ffv));
                if (ffv) check_eq("ffvec_end", o_fv, ffvec);
`endif
            end
        end
        if (!aborted && exp_err >= 0) check_eq("err_expected", err, exp_err);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; z_in = 1'b0; sel = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check_eq("reset_busy", o_busy, 0);
        check_eq("reset_done", o_done, 0);
        check_eq("reset_pass", o_pass, 0);
        check_eq("reset_err", o_err, 0);
        check_eq("reset_vec", o_vec, 0);
        check_eq("reset_xy", {o_x, o_y}, 0);

        run(0, 0, 0, 0, 0);
        run(1, 0, 0, 0, 3);
        run(2, 0, 0, 0, 2);
        for (int k = 0; k < 6; k++) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            run(3, 0, 0, 0, -1);
        end
        run(1, 0, 0, 1, -1);
        repeat (2) begin
            @(negedge clk);
            check_eq("idle_busy", o_busy, 0);
        end
        run(0, 1, 0, 0, 0);
        run(0, 1, 0, 0, 0);
        run(0, 1, 0, 0, 0);
        start = 1'b0;

        sel = 1'b1;
        @(negedge clk);
        run(1, 0, 20, 0, 15);
        run(3, 0, 40, 0, -1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
